// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath: default ring size, modulus,
// BRAM region bases (word indices) and the pointwise-multiply FSM states.
package ntt_pkg;

    localparam int N      = 64;
    localparam int Q      = 12289;
    localparam int A_BASE = 0;
    localparam int B_BASE = N;
    localparam int C_BASE = 2 * N;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        MUL,
        WR,
        DONE
    } pw_state_e;

endpackage

// File: rtl/mod_mul.sv
// Registered 32x32 -> 64 multiply followed by reduction mod Q.
// The result appears one cycle after en is sampled high.
module mod_mul #(
    parameter int Q = 12289
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r
);

    logic [63:0] prod;
    logic [63:0] red;
    logic        unused_red_hi;

    assign prod = 64'(a) * 64'(b);
    // Constant divisor: the remainder is always < Q, so only the low word matters.
    assign red  = prod % 64'(Q);
    assign unused_red_hi = ^red[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (en) begin
            r <= red[31:0];
        end
    end

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Pointwise C[i] = A[i]*B[i] mod Q over one shared BRAM port, one element at a time.
// Optional operand range checking is enabled by defining PW_OPERAND_CHECK_EN.
module ntt_pointwise_mul
    import ntt_pkg::*;
#(
    parameter int N        = ntt_pkg::N,
    parameter int Q        = ntt_pkg::Q,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  BRAM_addr_0,
    output logic        BRAM_clk_0,
    output logic [63:0] BRAM_din_0,
    input  logic [63:0] BRAM_dout_0,
    output logic        BRAM_en_0,
    output logic        BRAM_we_0,
    output logic        pw_done,
    output logic        pw_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [7:0] A_IDX = 8'(0);
    localparam logic [7:0] B_IDX = 8'(N);
    localparam logic [7:0] C_IDX = 8'(2 * N);

    pw_state_e     state, state_nxt;
    logic [IW-1:0] idx;
    logic [WW-1:0] wcnt;
    logic [31:0]   a_op, b_op, prod;
    logic [7:0]    widx;
    logic          wait_last, go, last_elem, in_wait;

    assign in_wait   = (state == WAIT_A) || (state == WAIT_B);
    assign wait_last = (wcnt == WW'(READ_LAT - 1));
    assign go        = start && ((state == IDLE) || (state == DONE));
    assign last_elem = (idx == IW'(N - 1));

    assign BRAM_clk_0  = clk;
    assign BRAM_addr_0 = {widx, 2'b00};
    assign BRAM_din_0  = {32'h0, prod};

    always_comb begin
        state_nxt = state;
        widx      = '0;
        BRAM_en_0 = 1'b1;
        BRAM_we_0 = 1'b0;
        case (state)
            IDLE, DONE: begin
                BRAM_en_0 = 1'b0;
                if (start) state_nxt = RD_A;
            end
            RD_A: begin
                widx      = A_IDX + 8'(idx);
                state_nxt = WAIT_A;
            end
            WAIT_A: begin
                widx = A_IDX + 8'(idx);
                if (wait_last) state_nxt = RD_B;
            end
            RD_B: begin
                widx      = B_IDX + 8'(idx);
                state_nxt = WAIT_B;
            end
            WAIT_B: begin
                widx = B_IDX + 8'(idx);
                if (wait_last) state_nxt = MUL;
            end
            MUL: begin
                widx      = C_IDX + 8'(idx);
                state_nxt = WR;
            end
            WR: begin
                widx      = C_IDX + 8'(idx);
                BRAM_we_0 = 1'b1;
                state_nxt = last_elem ? DONE : RD_A;
            end
            default: begin
                BRAM_en_0 = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            wcnt    <= '0;
            a_op    <= '0;
            b_op    <= '0;
            pw_done <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= (in_wait && !wait_last) ? wcnt + 1'b1 : '0;
            if (state == WAIT_A && wait_last) a_op <= BRAM_dout_0[31:0];
            if (state == WAIT_B && wait_last) b_op <= BRAM_dout_0[31:0];
            // idx stays at N-1 after the final write so nothing can wrap.
            if (go) begin
                idx     <= '0;
                pw_done <= 1'b0;
            end else if (state == WR) begin
                if (last_elem) pw_done <= 1'b1;
                else           idx     <= idx + 1'b1;
            end
        end
    end

    mod_mul #(.Q(Q)) u_mod_mul (
        .clk (clk),
        .rst (rst),
        .en  (state == MUL),
        .a   (a_op),
        .b   (b_op),
        .r   (prod)
    );

`ifdef PW_OPERAND_CHECK_EN
    logic op_bad;
    logic err_q;

    assign op_bad = in_wait && wait_last &&
                    ((BRAM_dout_0[63:32] != 32'h0) || (BRAM_dout_0[31:0] >= 32'(Q)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (go) begin
            err_q <= 1'b0;
        end else if (op_bad) begin
            err_q <= 1'b1;
        end
    end

    assign pw_err = err_q;
`else
    logic unused_dout_hi;
    assign unused_dout_hi = ^BRAM_dout_0[63:32];
    assign pw_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Bench for ntt_pointwise_mul: two instances (READ_LAT 2 and 3) on BRAM models,
// table vectors plus randomized passes checked against an arithmetic model.
module tb_ntt_pointwise_mul;

    localparam int N = 64;
    localparam int Q = 12289;
    localparam logic [63:0] SENT = 64'hDEAD_BEEF_0000_0000;
`ifdef PW_OPERAND_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [1:0]       start, bclk, en, we, done, err;
    logic [1:0][9:0]  addr;
    logic [1:0][63:0] din, dout;

    logic [63:0] ma [2][N];
    logic [63:0] mb [2][N];
    vec_t        tbl [9];
    int          nchk, npass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : bram
        localparam int RL = (g == 0) ? 2 : 3;
        logic [63:0] mem  [256];
        logic [63:0] pipe [4];

        always @(posedge clk) begin
            if (en[g]) pipe[0] <= mem[addr[g][9:2]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            if (en[g] && we[g]) mem[addr[g][9:2]] = din[g];
        end
        assign dout[g] = pipe[RL-1];

        ntt_pointwise_mul #(.READ_LAT(RL)) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .BRAM_addr_0 (addr[g]),
            .BRAM_clk_0  (bclk[g]),
            .BRAM_din_0  (din[g]),
            .BRAM_dout_0 (dout[g]),
            .BRAM_en_0   (en[g]),
            .BRAM_we_0   (we[g]),
            .pw_done     (done[g]),
            .pw_err      (err[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic mem_wr(input int d, input int i, input logic [63:0] v);
        if (d == 0) bram[0].mem[i] = v;
        else        bram[1].mem[i] = v;
    endtask

    function automatic logic [63:0] mem_rd(input int d, input int i);
        return (d == 0) ? bram[0].mem[i] : bram[1].mem[i];
    endfunction

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        p = {32'h0, a[31:0]} * {32'h0, b[31:0]};
        return p % 64'(Q);
    endfunction

    function automatic logic exp_err(input int d);
        logic e;
        e = 1'b0;
        for (int i = 0; i < N; i++)
            if (ma[d][i][63:32] != 0 || ma[d][i][31:0] >= 32'(Q) ||
                mb[d][i][63:32] != 0 || mb[d][i][31:0] >= 32'(Q)) e = 1'b1;
        return CHK & e;
    endfunction

    // mode 0 ramp, 1 all Q-1, 2 table+random, 3 full 32-bit random, 4 B[5]=Q
    task automatic load(input int d, input int mode);
        for (int i = 0; i < N; i++) begin
            logic [63:0] a, b;
            a = 64'($urandom_range(Q - 1, 0));
            b = 64'($urandom_range(Q - 1, 0));
            case (mode)
                0: begin a = 64'(i); b = 64'd2; end
                1: begin a = 64'(Q - 1); b = 64'(Q - 1); end
                2: if (i < 9) begin a = tbl[i].a; b = tbl[i].b; end
                3: begin a = {32'h0, $urandom()}; b = {32'h0, $urandom()}; end
                default: if (i == 5) b = 64'(Q);
            endcase
            ma[d][i] = a;
            mb[d][i] = b;
            mem_wr(d, i, a);
            mem_wr(d, N + i, b);
            mem_wr(d, 2 * N + i, SENT | 64'(i));
        end
    endtask

    task automatic run_pass(input int d, input int exp_cyc, input bit pulses, input string tag);
        int cyc, wcnt;
        bit en_bad, addr_bad, quiet_bad;
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        cyc = 0; wcnt = 0; en_bad = 0; addr_bad = 0; quiet_bad = 0;
        check({tag, " done_clr"}, 64'(done[d]), 64'd0);
        check({tag, " err_clr"}, 64'(err[d]), 64'd0);
        while (!done[d] && cyc < exp_cyc + 200) begin
            if (en[d] !== 1'b1) en_bad = 1;
            if (we[d]) begin
                if (addr[d] != 10'((2 * N + wcnt) * 4)) addr_bad = 1;
                wcnt++;
            end
            start[d] = pulses && (cyc % 97 == 13);
            @(negedge clk);
            cyc++;
        end
        start[d] = 1'b0;
        check({tag, " cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " writes"}, 64'(wcnt), 64'(N));
        check({tag, " en_active"}, 64'(en_bad), 64'd0);
        check({tag, " wr_addr"}, 64'(addr_bad), 64'd0);
        repeat (16) begin
            if (en[d] || we[d] || !done[d]) quiet_bad = 1;
            @(negedge clk);
        end
        check({tag, " quiet_after_done"}, 64'(quiet_bad), 64'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("%s C[%0d]", tag, i), mem_rd(d, 2 * N + i), ref_mul(ma[d][i], mb[d][i]));
        check({tag, " err"}, 64'(err[d]), 64'(exp_err(d)));
    endtask

    initial begin
        int guard, wcnt;
        bit we_bad;
        nchk = 0; npass = 0;
        tbl[0] = '{64'd0,     64'd5,     64'd0};
        tbl[1] = '{64'd1,     64'd1,     64'd1};
        tbl[2] = '{64'd12288, 64'd12288, 64'd1};
        tbl[3] = '{64'd12288, 64'd2,     64'd12287};
        tbl[4] = '{64'd100,   64'd200,   64'd7711};
        tbl[5] = '{64'h0000_0005_0000_0003, 64'd7, 64'd21};
        tbl[6] = '{64'd12289, 64'd100,   64'd0};
        tbl[7] = '{64'd3000,  64'd5,     64'd2711};
        tbl[8] = '{64'd65536, 64'd65536, 64'd10952};

        rst = 1'b1;
        start = '0;
        #3;
        check("rst en", 64'(en), 64'd0);
        check("rst we", 64'(we), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst din", din[0], 64'd0);
        check("bram_clk lo", {62'd0, bclk}, {62'd0, clk, clk});
        #4;
        check("bram_clk hi", {62'd0, bclk}, {62'd0, clk, clk});
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        load(0, 0);
        run_pass(0, 512, 1'b0, "ramp");
        check("ramp C[63]", mem_rd(0, 2 * N + 63), 64'd126);

        load(0, 1);
        run_pass(0, 512, 1'b1, "qm1_pulsed");

        load(0, 2);
        run_pass(0, 512, 1'b0, "table");
        for (int k = 0; k < 9; k++)
            check($sformatf("tbl[%0d]", k), mem_rd(0, 2 * N + k), tbl[k].c);

        load(0, 4);
        run_pass(0, 512, 1'b0, "bad_b5");
        check("bad_b5 C[5]", mem_rd(0, 2 * N + 5), 64'd0);

        // Reset in the middle of element 10, then a clean full pass.
        load(0, 3);
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        wcnt = 0; guard = 0;
        while (wcnt < 10 && guard < 2000) begin
            if (we[0]) wcnt++;
            @(negedge clk);
            guard++;
        end
        check("rst_mid reached", 64'(wcnt), 64'd10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid we", 64'(we[0]), 64'd0);
        check("rst_mid en", 64'(en[0]), 64'd0);
        check("rst_mid din", din[0], 64'd0);
        we_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (we[0] || en[0]) we_bad = 1;
        end
        check("rst_mid held", 64'(we_bad), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid idle", 64'({en[0], we[0], done[0]}), 64'd0);
        for (int i = 11; i < N; i++)
            check($sformatf("rst_mid C[%0d] untouched", i), mem_rd(0, 2 * N + i), SENT | 64'(i));
        run_pass(0, 512, 1'b0, "after_rst");

        load(1, 3);
        run_pass(1, 640, 1'b1, "lat3");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/ntt_pointwise_mul.md
NTT_POINTWISE_MUL -- requirements
Module: ntt_pointwise_mul

Interface
- REQ-001 Parameter N, default 64: number of coefficients per vector.
- REQ-002 Parameter Q, default 12289: prime modulus; all products are reduced mod Q.
- REQ-003 Parameter READ_LAT, default 2: BRAM read latency in cycles, from address presented to dout valid.
- REQ-004 clk  input  1: the single clock; every register is clocked on its rising edge.
- REQ-005 rst  input  1: asynchronous, active-high reset.
- REQ-006 start  input  1: single-cycle request to begin one pointwise pass.
- REQ-007 BRAM_addr_0  output  10: byte address, equal to word index << 2.
- REQ-008 BRAM_clk_0  output  1: equal to clk.
- REQ-009 BRAM_din_0  output  64: write data.
- REQ-010 BRAM_dout_0  input  64: read data.
- REQ-011 BRAM_en_0  output  1: BRAM enable.
- REQ-012 BRAM_we_0  output  1: BRAM write enable.
- REQ-013 pw_done  output  1: level; high when a pass has completed.
- REQ-014 pw_err  output  1: sticky operand-range error flag (see Configuration).

Function
- REQ-015 Memory map, in word indices: A occupies 0..N-1; B (NTT output from the upstream stage) occupies N..2N-1; C results occupy 2N..3N-1.
- REQ-016 For each i from 0 to N-1, the block SHALL write C[i] = (A[i][31:0] * B[i][31:0]) mod Q, zero-extended to 64 bits.
- REQ-017 FSM states and transitions:
  - IDLE -> RD_A on start.
  - RD_A: 1 cycle.
  - WAIT_A: READ_LAT cycles; A captured on the last cycle.
  - RD_B: 1 cycle.
  - WAIT_B: READ_LAT cycles; B captured on the last cycle.
  - MUL: 1 cycle; registered reduction.
  - WR: 1 cycle with BRAM_we_0 = 1.
  - From WR: -> RD_A if i < N-1, else -> DONE.
  - DONE -> RD_A on start.
- REQ-018 Cycles per element SHALL be 2*READ_LAT + 4; the defaults give 8 cycles per element and 512 cycles from the start cycle to pw_done rising.
- REQ-019 BRAM_en_0 SHALL be 1 in every state except IDLE and DONE.
- REQ-020 BRAM_we_0 SHALL be 1 only in WR.
- REQ-021 BRAM_addr_0 SHALL hold the word index of the current access for the whole RD_x/WAIT_x/WR interval.
- REQ-022 start SHALL be ignored in every state except IDLE and DONE.
- REQ-023 A start accepted in DONE SHALL clear pw_done and pw_err in the same cycle.
- REQ-024 The element index SHALL NOT wrap: after the write of i = N-1, no further BRAM access occurs.
- REQ-025 The multiply SHALL be 32x32 -> 64 bits, and the reduction result SHALL be less than Q.

Reset
- REQ-026 While rst is high, the block SHALL be in state IDLE, with the index, pw_done, pw_err, BRAM_we_0, BRAM_en_0 and BRAM_din_0 all at 0.
- REQ-027 Reset asserted mid-pass SHALL abort immediately with no further write; partial C contents are undefined.

Configuration
- REQ-028 Macro PW_OPERAND_CHECK_EN, defined: pw_err SHALL be set when a captured A or B has bits [63:32] nonzero or low word >= Q. The offending result is still written, and the pass continues.
- REQ-029 Macro PW_OPERAND_CHECK_EN, undefined: pw_err SHALL be constant 0, and no compare logic is synthesized.

Structure
- REQ-030 Shared package ntt_pkg SHALL hold N, Q, the A/B/C base indices, and the FSM state enum type; it is shared with the NTT stage.
- REQ-031 Sub-module mod_mul SHALL implement the registered 32x32 multiply and mod-Q reduction with 1-cycle latency.

Verification
- REQ-032 Scenario: A[i] = i, B[i] = 2, start -> C[i] = 2i for all i; pw_done rises exactly 512 cycles after start.
- REQ-033 Scenario: A[i] = 12288, B[i] = 12288 -> every C[i] = 1 (since (Q-1)^2 mod Q = 1).
- REQ-034 Scenario: rst pulsed during element 10 -> BRAM_we_0 = 0 from assertion onward; C[11..63] are untouched; a subsequent start completes a full, correct pass.
- REQ-035 Scenario: start pulsed repeatedly mid-pass -> no restart; the cycle count is still 512.
- REQ-036 Scenario: with PW_OPERAND_CHECK_EN defined, set B[5] = 12289 -> pw_err = 1 after element 5 and stays high; C[5] = 0; pw_err clears on the next start.
- REQ-037 Scenario: READ_LAT = 3 -> 10 cycles per element, 640 cycles total, with correct results.
